// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: divide-ratio update handshake between config block and divider
interface clk_div_ctrl_if #(parameter int DIV_W = 8) ();
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free integer clock divider with boundary-synchronised ratio updates
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] phase,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, RUN, RUN_PEND} state_t;
  state_t           state, state_n;
  logic [DIV_W-1:0] cur_div, cur_div_n, pend_div, pend_div_n, count, count_n;
  logic [DIV_W:0]   half;
  logic             pending, pending_n, clk_n, tick_n, err_q, accept, illegal, wrap;
  assign cfg.cfg_ready = state != RUN_PEND;
  assign cfg.cfg_err   = err_q;
  assign running       = state != IDLE;
  assign phase         = count;
  // next state, ratio bookkeeping and the registered clk_out/tick for the coming cycle
  always_comb begin
    accept     = cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_div >= DIV_W'(2);
    illegal    = cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_div < DIV_W'(2);
    wrap       = count == cur_div - DIV_W'(1);
    state_n    = state;
    cur_div_n  = cur_div;
    pend_div_n = pend_div;
    pending_n  = pending;
    count_n    = DIV_W'(0);
    if (state == IDLE) begin
      cur_div_n = accept ? cfg.cfg_div : cur_div;
      state_n   = en ? RUN : IDLE;
    end else if (wrap) begin
      cur_div_n = pending ? pend_div : accept ? cfg.cfg_div : cur_div;
      pending_n = 1'b0;
      state_n   = en ? RUN : IDLE;
    end else begin
      count_n    = count + DIV_W'(1);
      pend_div_n = accept ? cfg.cfg_div : pend_div;
      pending_n  = pending || accept;
      state_n    = accept ? RUN_PEND : state;
    end
    half   = ({1'b0, cur_div_n} + (DIV_W+1)'(1)) >> 1;
    clk_n  = state_n != IDLE && {1'b0, count_n} < half;
    tick_n = state_n != IDLE && count_n == cur_div_n - DIV_W'(1);
  end
  // state and output registers, reset wins over everything
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= IDLE;
      cur_div  <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      count    <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cur_div  <= cur_div_n;
      pend_div <= pend_div_n;
      pending  <= pending_n;
      count    <= count_n;
      clk_out  <= clk_n;
      tick     <= tick_n;
      err_q    <= illegal;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench comparing the divider against a cycle model
module tb_clk_div_ctrl;
  logic       clk_in = 1'b0;
  logic       reset, en, clk_out, tick, running;
  logic [7:0] phase;
  int         n_chk = 0, n_pass = 0;
  int         m_st, m_div, m_pdiv, m_cnt;
  bit         m_err;
  typedef struct {
    logic       clk, tick, running, ready, err;
    logic [7:0] phase;
  } exp_t;
  exp_t exp_q[$];
  clk_div_ctrl_if #(.DIV_W(8)) cfg ();
  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(3)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .cfg(cfg),
    .clk_out(clk_out), .tick(tick), .phase(phase), .running(running)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask
  task automatic model_update();
    bit rdy, acc;
    if (reset) begin
      m_st = 0; m_div = 3; m_pdiv = 0; m_cnt = 0; m_err = 0;
      return;
    end
    rdy   = m_st != 2;
    acc   = cfg.cfg_valid && rdy && cfg.cfg_div >= 2;
    m_err = cfg.cfg_valid && rdy && cfg.cfg_div < 2;
    if (m_st == 0) begin
      if (acc) m_div = cfg.cfg_div;
      if (en) begin m_st = 1; m_cnt = 0; end
    end else if (m_cnt == m_div - 1) begin
      if (m_st == 2) m_div = m_pdiv;
      else if (acc) m_div = cfg.cfg_div;
      m_cnt = 0;
      m_st  = en ? 1 : 0;
    end else begin
      m_cnt++;
      if (acc) begin m_pdiv = cfg.cfg_div; m_st = 2; end
    end
  endtask
  task automatic step();
    exp_t e;
    model_update();
    e.clk     = m_st != 0 && m_cnt < (m_div + 1) / 2;
    e.tick    = m_st != 0 && m_cnt == m_div - 1;
    e.phase   = 8'(m_cnt);
    e.running = m_st != 0;
    e.ready   = m_st != 2;
    e.err     = m_err;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    chk("clk_out", clk_out, e.clk);
    chk("tick", tick, e.tick);
    chk("phase", phase, e.phase);
    chk("running", running, e.running);
    chk("cfg_ready", cfg.cfg_ready, e.ready);
    chk("cfg_err", cfg.cfg_err, e.err);
  endtask
  task automatic wait_phase(input int p);
    for (int i = 0; i < 600 && m_cnt != p; i++) step();
    chk("phase_reach", phase, p);
  endtask
  task automatic to_idle();
    for (int i = 0; i < 600 && m_st != 0; i++) step();
    chk("to_idle", running, 0);
  endtask
  initial begin
    reset = 1; en = 0; cfg.cfg_valid = 0; cfg.cfg_div = 0;
    step(); step();
    reset = 0;
    step();
    en = 1;
    repeat (9) step();
    wait_phase(0);
    cfg.cfg_valid = 1; cfg.cfg_div = 5;
    step();
    cfg.cfg_valid = 0;
    repeat (12) step();
    cfg.cfg_valid = 1; cfg.cfg_div = 1;
    step();
    cfg.cfg_valid = 0;
    repeat (3) step();
    cfg.cfg_valid = 1; cfg.cfg_div = 0;
    step();
    cfg.cfg_valid = 0;
    repeat (6) step();
    wait_phase(0);
    cfg.cfg_valid = 1; cfg.cfg_div = 6;
    step();
    cfg.cfg_div = 1;
    repeat (2) step();
    cfg.cfg_valid = 0;
    repeat (10) step();
    wait_phase(m_div - 1);
    cfg.cfg_valid = 1; cfg.cfg_div = 4;
    step();
    cfg.cfg_valid = 0;
    repeat (9) step();
    wait_phase(0);
    en = 0;
    repeat (5) step();
    en = 1;
    repeat (3) step();
    en = 0;
    to_idle();
    cfg.cfg_valid = 1; cfg.cfg_div = 2;
    step();
    cfg.cfg_valid = 0; en = 1;
    repeat (8) step();
    en = 0;
    to_idle();
    en = 1; cfg.cfg_valid = 1; cfg.cfg_div = 6;
    step();
    cfg.cfg_valid = 0;
    repeat (13) step();
    wait_phase(0);
    cfg.cfg_valid = 1; cfg.cfg_div = 7;
    step();
    cfg.cfg_valid = 0; en = 0;
    to_idle();
    en = 1;
    repeat (15) step();
    en = 0;
    to_idle();
    cfg.cfg_valid = 1; cfg.cfg_div = 255;
    step();
    cfg.cfg_valid = 0; en = 1;
    repeat (520) step();
    en = 0;
    to_idle();
    cfg.cfg_valid = 1; cfg.cfg_div = 4;
    step();
    cfg.cfg_valid = 0; en = 1;
    step();
    wait_phase(0);
    cfg.cfg_valid = 1; cfg.cfg_div = 7;
    step();
    cfg.cfg_valid = 0;
    step();
    reset = 1;
    step();
    reset = 0; en = 0;
    step();
    en = 1;
    repeat (9) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller for the team's integer clock dividers. It generates a divided clock (clk_out) and a one-cycle period tick from clk_in, and accepts divide-ratio updates over a valid/ready handshake. Each update is applied only at a period boundary, so clk_out never produces a runt pulse. It sits between the configuration register block and the clock-enable consumers.

Parameters:
DIV_W, 8, width of the divide ratio and phase counter.
DEFAULT_DIV, 3, divide ratio loaded at reset; must be >= 2 and < 2^DIV_W.

Ports:
clk_in  input  1  single clock; every register updates on its rising edge.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_in.
en  input  1  run request; sampled only in IDLE and at the period wrap.
cfg_valid  input  1  a new ratio is offered.
cfg_div  input  DIV_W  offered ratio; legal values are >= 2.
cfg_ready  output  1  high when an offered ratio can be accepted.
cfg_err  output  1  one-cycle pulse when an illegal ratio (0 or 1) is offered.
clk_out  output  1  registered divided clock.
tick  output  1  one-cycle pulse in the last cycle of each period.
phase  output  DIV_W  current count, 0..D-1.
running  output  1  high while in RUN or RUN_PEND.

Behaviour:
- Reset values: state=IDLE, cur_div=DEFAULT_DIV, count=0, pending=0, clk_out=0, tick=0, cfg_ready=1, cfg_err=0, running=0. Reset has priority over every other event.
- Terms: D = cur_div; H = ceil(D/2). All outputs are registered.
- Handshake: a transfer occurs when cfg_valid && cfg_ready && cfg_div >= 2.
- Illegal offer: cfg_valid && cfg_ready && cfg_div < 2 -> cfg_err=1 in the next cycle only. No other state changes.
- IDLE state:
  - clk_out=0, tick=0, count=0.
  - An accepted cfg loads cur_div at that edge.
  - en=1 -> RUN at the next edge, with count=0 and clk_out=1.
  - If en and cfg arrive in the same cycle, the new ratio is used for the first period.
- RUN state:
  - count increments each cycle.
  - clk_out=1 while count < H, otherwise 0.
  - tick=1 while count == D-1.
- Mid-period accept (RUN, count != D-1):
  - The ratio is stored in pend_div and pending is set.
  - State moves to RUN_PEND; cfg_ready goes to 0 from the next cycle.
- Wrap edge (count == D-1):
  - If pending: cur_div <= pend_div, pending <= 0, cfg_ready <= 1.
  - An accept on the wrap edge itself loads cur_div directly, effective for the period that starts at that edge; cfg_ready stays 1.
  - en=1 -> count <= 0, and the state becomes RUN.
  - en=0 -> IDLE; clk_out, running and count go to 0.
  - If a pending update exists when en=0, it is applied to cur_div before entering IDLE.
- en changes between wraps are ignored. A period is never truncated.
- cfg_ready=0 only in RUN_PEND. cfg_valid is ignored while cfg_ready=0, and cfg_err is not raised in that case.
- Duty cycle: even D gives 50%. Odd D gives H high cycles and H-1 low cycles.
- Range: D = 2^DIV_W-1 is legal; count must not overflow.

Test Plan:
1. Reset, then en=1 with the default ratio -> running=1 from the next cycle. clk_out repeats 1,1,0; phase repeats 0,1,2; tick=1 only when phase=2.
2. In IDLE, cfg_div=4 accepted, then en=1 -> clk_out repeats 1,1,0,0; tick=1 every 4th cycle.
3. RUN at D=3; cfg_div=5 accepted at phase 0 -> cfg_ready=0 for 2 cycles. The current period completes as 1,1,0, then clk_out runs 1,1,1,0,0 and cfg_ready returns to 1 at the wrap.
4. cfg_div=1 with cfg_valid=1 in RUN -> cfg_err pulses for exactly one cycle; the clk_out/tick pattern and cur_div are unchanged.
5. en drops at phase 0 of D=4 -> the period finishes as 1,1,0,0 with tick at phase 3; then running=0, clk_out=0, phase=0. en reasserted -> clk_out=1 in the following cycle.
6. reset=1 in RUN_PEND (pend_div=7) -> the next cycle shows all reset values and cur_div=3; the pending update is discarded. After en=1 the pattern is 1,1,0.
